// File: rtl/trace_replay_pkg.sv
// Shared opcodes, replay FSM states and width helpers for the multi-channel
// trace replayer.
package trace_replay_pkg;

  localparam logic [3:0] op_nop    = 4'd0;
  localparam logic [3:0] op_send   = 4'd1;
  localparam logic [3:0] op_recv   = 4'd2;
  localparam logic [3:0] op_wait   = 4'd3;
  localparam logic [3:0] op_finish = 4'd4;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_run   = 2'd1,
    st_waitc = 2'd2,
    st_done  = 2'd3
  } replay_state_e;

  // clog2 that never returns 0, so single-entry fields still get one bit
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trace_masked_cmp.sv
// Masked payload compare: a set mask bit means that bit must match.
module trace_masked_cmp #(
  parameter int payload_width_p = 64
) (
  input  logic [payload_width_p-1:0] data_i,
  input  logic [payload_width_p-1:0] exp_i,
  input  logic [payload_width_p-1:0] mask_i,
  output logic                       mismatch_o
);

  assign mismatch_o = |((data_i ^ exp_i) & mask_i);

endmodule

// File: rtl/multi_chan_trace_replay.sv
// Walks a combinational trace ROM, driving/checking one of num_chan_p channel
// pairs per entry, with masked compare, per-command timeout and error latching.
module multi_chan_trace_replay
  import trace_replay_pkg::*;
#(
  parameter int payload_width_p  = 64,
  parameter int rom_addr_width_p = 4,
  parameter int num_chan_p       = 2,
  parameter int timeout_p        = 1024,
  parameter int halt_on_error_p  = 0,
  localparam int chan_w = safe_clog2(num_chan_p),
  localparam int rom_w  = 4 + chan_w + 2 * payload_width_p
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_i,
  output logic [num_chan_p-1:0]            v_o,
  output logic [payload_width_p-1:0]       data_o,
  input  logic [num_chan_p-1:0]            rdy_i,
  input  logic [num_chan_p-1:0]            v_i,
  input  logic [num_chan_p*payload_width_p-1:0] data_i,
  output logic [num_chan_p-1:0]            rdy_o,
  output logic [rom_addr_width_p-1:0]      rom_addr_o,
  input  logic [rom_w-1:0]                 rom_data_i,
  output logic                             done_o,
  output logic                             error_o,
  output logic [15:0]                      err_count_o,
  output logic [rom_addr_width_p-1:0]      err_addr_o
);

  // Handshakes: a send completes when v_o[c] & rdy_i[c], a receive when
  // v_i[c] & rdy_o[c], both sampled at the rising edge of clk.

  localparam int stall_w = safe_clog2(timeout_p + 1);
  localparam logic [stall_w-1:0] stall_last = stall_w'(timeout_p - 1);

  typedef struct packed {
    logic [3:0]                 op;
    logic [chan_w-1:0]          chan;
    logic [payload_width_p-1:0] data;
    logic [payload_width_p-1:0] mask;
  } trace_rom_entry_s;

  trace_rom_entry_s entry;
  assign entry = rom_data_i;

  replay_state_e               state_q, state_d;
  logic [rom_addr_width_p-1:0] addr_q, addr_d;
  logic [rom_addr_width_p-1:0] err_addr_q, err_addr_d;
  logic [stall_w-1:0]          stall_q, stall_d;
  logic [15:0]                 wait_q, wait_d;
  logic [15:0]                 err_count_q, err_count_d;
  logic                        error_q, error_d;

  logic [num_chan_p-1:0]      chan_sel;
  logic [payload_width_p-1:0] resp_data;
  logic                       mismatch;
  logic                       advance;
  logic [1:0]                 err_inc;
  logic [16:0]                err_sum;

  // Out-of-range channel numbers leave chan_sel all zero
  always_comb begin
    chan_sel  = '0;
    resp_data = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (entry.chan == chan_w'(c)) begin
        chan_sel[c] = 1'b1;
        resp_data   = data_i[c*payload_width_p +: payload_width_p];
      end
    end
  end

  trace_masked_cmp #(
    .payload_width_p(payload_width_p)
  ) u_cmp (
    .data_i    (resp_data),
    .exp_i     (entry.data),
    .mask_i    (entry.mask),
    .mismatch_o(mismatch)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stall_d     = stall_q;
    wait_d      = wait_q;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    v_o         = '0;
    rdy_o       = '0;
    data_o      = '0;
    advance     = 1'b0;
    err_inc     = 2'd0;
    err_sum     = '0;

    unique case (state_q)
      st_idle: begin
        if (en_i) state_d = st_run;
      end
      st_run: begin
        if (en_i) begin
          case (entry.op)
            op_nop: advance = 1'b1;
            op_send, op_recv: begin
              if (chan_sel == '0) begin
                err_inc = 2'd1;
                advance = 1'b1;
              end else begin
                if (entry.op == op_send) begin
                  v_o    = chan_sel;
                  data_o = entry.data;
                end else begin
                  rdy_o  = chan_sel;
                end
                if ((entry.op == op_send) ? |(chan_sel & rdy_i) : |(chan_sel & v_i)) begin
                  advance = 1'b1;
                  if (entry.op == op_recv && mismatch) err_inc = 2'd1;
                end else if (stall_q == stall_last) begin
                  err_inc = 2'd1;
                  advance = 1'b1;
                end else begin
                  stall_d = stall_q + stall_w'(1);
                end
              end
            end
            op_wait: begin
              state_d = st_waitc;
              wait_d  = entry.data[15:0];
            end
            op_finish: state_d = st_done;
            default: begin
              err_inc = 2'd1;
              advance = 1'b1;
            end
          endcase
        end
      end
      st_waitc: begin
        if (wait_q == 16'd0) advance = 1'b1;
        else                 wait_d  = wait_q - 16'd1;
      end
      st_done: ;
      default: state_d = st_idle;
    endcase

    // The address never wraps: stepping past the last entry is a runaway
    if (advance) begin
      stall_d = '0;
      state_d = st_run;
      if (addr_q == '1) begin
        err_inc = err_inc + 2'd1;
        state_d = st_done;
      end else begin
        addr_d = addr_q + rom_addr_width_p'(1);
      end
    end

    if (err_inc != 2'd0) begin
      error_d     = 1'b1;
      if (!error_q) err_addr_d = addr_q;
      err_sum     = {1'b0, err_count_q} + {15'b0, err_inc};
      err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (halt_on_error_p != 0) state_d = st_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= st_idle;
      addr_q      <= '0;
      stall_q     <= '0;
      wait_q      <= '0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stall_q     <= stall_d;
      wait_q      <= wait_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign done_o      = (state_q == st_done);
  assign error_o     = error_q;
  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_multi_chan_trace_replay.sv
// Bench for multi_chan_trace_replay: table of masked-receive cases plus
// hand-written traces for wait, timeout, halt, illegal, reset and runaway.
module tb_multi_chan_trace_replay;

  localparam int pw = 64;
  localparam int aw = 4;
  localparam int nc = 3;
  localparam int cw = 2;
  localparam int rw = 4 + cw + 2 * pw;

  localparam logic [3:0] k_nop    = 4'd0;
  localparam logic [3:0] k_send   = 4'd1;
  localparam logic [3:0] k_recv   = 4'd2;
  localparam logic [3:0] k_wait   = 4'd3;
  localparam logic [3:0] k_finish = 4'd4;
  localparam logic [3:0] k_ill    = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_i;
  logic [nc-1:0] rdy_i, v_i;
  logic [nc*pw-1:0] data_i;

  logic [nc-1:0] v_o, rdy_o, h_v_o, h_rdy_o;
  logic [pw-1:0] data_o, h_data_o;
  logic [aw-1:0] rom_addr, h_rom_addr, err_addr, h_err_addr;
  logic [rw-1:0] rom_data, h_rom_data;
  logic          done, h_done, error, h_error;
  logic [15:0]   err_count, h_err_count;

  logic [rw-1:0] rom [16];
  assign rom_data   = rom[rom_addr];
  assign h_rom_data = rom[h_rom_addr];

  multi_chan_trace_replay #(
    .payload_width_p(pw), .rom_addr_width_p(aw), .num_chan_p(nc),
    .timeout_p(8), .halt_on_error_p(0)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .v_o(v_o), .data_o(data_o),
    .rdy_i(rdy_i), .v_i(v_i), .data_i(data_i), .rdy_o(rdy_o),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .done_o(done),
    .error_o(error), .err_count_o(err_count), .err_addr_o(err_addr)
  );

  multi_chan_trace_replay #(
    .payload_width_p(pw), .rom_addr_width_p(aw), .num_chan_p(nc),
    .timeout_p(8), .halt_on_error_p(1)
  ) dut_h (
    .clk(clk), .rst(rst), .en_i(en_i), .v_o(h_v_o), .data_o(h_data_o),
    .rdy_i(rdy_i), .v_i(v_i), .data_i(data_i), .rdy_o(h_rdy_o),
    .rom_addr_o(h_rom_addr), .rom_data_i(h_rom_data), .done_o(h_done),
    .error_o(h_error), .err_count_o(h_err_count), .err_addr_o(h_err_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [pw+1:0] exp_q[$];
  int hs_q[$];
  bit any_pulse;
  logic [cw-1:0] mon_ch;
  logic [pw+1:0] mon_e;

  typedef struct {
    logic [pw-1:0] exp;
    logic [pw-1:0] mask;
    logic [pw-1:0] resp;
    logic          err;
  } recv_vec_t;
  recv_vec_t vecs[8];

  function automatic logic [rw-1:0] ent(input logic [3:0] op, input logic [cw-1:0] ch,
                                        input logic [pw-1:0] d, input logic [pw-1:0] m);
    return {op, ch, d, m};
  endfunction

  task automatic chk(input string name, input logic [pw-1:0] act, input logic [pw-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send scoreboard and one-hot watch on the non-halting instance
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if ((v_o | rdy_o) != '0) begin
        any_pulse = 1'b1;
        chk("one_hot", 64'($countones(v_o) + $countones(rdy_o)), 64'd1);
      end
      if ((v_o & rdy_i) != '0) begin
        mon_ch = '0;
        for (int c = 0; c < nc; c++) if (v_o[c]) mon_ch = cw'(c);
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got send ch %0d data %0h, none expected", mon_ch, data_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_chan", 64'(mon_ch), 64'(mon_e[pw+1:pw]));
          chk("sb_data", data_o, mon_e[pw-1:0]);
        end
      end
    end
  end

  task automatic fill_rom(input logic [3:0] op);
    for (int i = 0; i < 16; i++) rom[i] = ent(op, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    hs_q.delete();
    any_pulse = 1'b0;
  endtask

  task automatic run(input int budget, output int cycles);
    bit hit;
    cycles = 0;
    hit    = 1'b0;
    en_i   = 1'b1;
    while (!hit && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
      hit = done;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL run_budget: done_o still 0 after %0d cycles", budget);
    end
  endtask

  task automatic chk_status(input string tag, input int cycles, input int exp_cycles,
                            input logic [15:0] cnt, input logic [aw-1:0] eaddr);
    chk({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_error"}, 64'(error), 64'(cnt != 16'd0));
    chk({tag, "_count"}, 64'(err_count), 64'(cnt));
    chk({tag, "_eaddr"}, 64'(err_addr), 64'(eaddr));
    chk({tag, "_sb_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  int ncyc;
  logic [pw-1:0] a, b, c, d;
  logic [cw-1:0] rch;

  initial begin
    rst = 1'b1; en_i = 1'b0; rdy_i = '0; v_i = '0; data_i = '0;
    vecs[0] = '{64'hFF, 64'h0F, 64'hAF, 1'b0};
    vecs[1] = '{64'hFF, 64'hF0, 64'hAF, 1'b1};
    vecs[2] = '{64'h1234_5678_9ABC_DEF0, '1, 64'h1234_5678_9ABC_DEF0, 1'b0};
    vecs[3] = '{64'h0, 64'h0, '1, 1'b0};
    vecs[4] = '{64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1};
    for (int i = 5; i < 8; i++) begin
      vecs[i].exp  = {$urandom, $urandom};
      vecs[i].mask = {$urandom, $urandom};
      vecs[i].resp = (i == 5) ? vecs[i].exp : vecs[i].exp ^ (64'h1 << $urandom_range(63, 0));
      vecs[i].err  = |((vecs[i].resp ^ vecs[i].exp) & vecs[i].mask);
    end

    // Reset values
    fill_rom(k_finish);
    do_reset();
    chk("rst_v_o", 64'(v_o), 64'd0);
    chk("rst_rdy_o", 64'(rdy_o), 64'd0);
    chk("rst_data_o", data_o, 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_count", 64'(err_count), 64'd0);
    chk("rst_eaddr", 64'(err_addr), 64'd0);

    // Send, echoed receive, finish
    a = 64'hDEAD_BEEF_0123_4567;
    fill_rom(k_finish);
    rom[0] = ent(k_send, 2'd0, a, '0);
    rom[1] = ent(k_recv, 2'd1, a, '1);
    do_reset();
    rdy_i = '1; v_i = 3'b010; data_i = '0; data_i[pw +: pw] = a;
    exp_q.push_back({2'd0, a});
    run(50, ncyc);
    chk_status("echo", ncyc, 4, 16'd0, 4'd0);

    // Masked receive table
    for (int i = 0; i < 8; i++) begin
      fill_rom(k_finish);
      rom[0] = ent(k_nop, 2'd0, '0, '0);
      rom[1] = ent(k_recv, 2'd2, vecs[i].exp, vecs[i].mask);
      do_reset();
      rdy_i = '1; v_i = 3'b100; data_i = '0; data_i[2*pw +: pw] = vecs[i].resp;
      run(50, ncyc);
      chk_status($sformatf("recv%0d", i), ncyc, 4, vecs[i].err ? 16'd1 : 16'd0,
                 vecs[i].err ? 4'd1 : 4'd0);
    end

    // WAIT 5 between two sends: one decode cycle plus six counting cycles
    b = 64'h0B0B; c = 64'h0C0C;
    fill_rom(k_finish);
    rom[0] = ent(k_send, 2'd0, b, '0);
    rom[1] = ent(k_wait, 2'd0, 64'd5, '0);
    rom[2] = ent(k_send, 2'd1, c, '0);
    do_reset();
    rdy_i = '1; v_i = '0; data_i = '0;
    exp_q.push_back({2'd0, b});
    exp_q.push_back({2'd1, c});
    run(50, ncyc);
    chk_status("wait", ncyc, 11, 16'd0, 4'd0);
    chk("wait_hs_count", 64'(hs_q.size()), 64'd2);
    if (hs_q.size() == 2) chk("wait_gap", 64'(hs_q[1] - hs_q[0]), 64'd8);

    // Send timeout on a never-ready channel, then the next entry runs
    d = 64'h0D0D_0E0E;
    fill_rom(k_finish);
    rom[0] = ent(k_send, 2'd0, 64'h5555, '0);
    rom[1] = ent(k_send, 2'd1, d, '0);
    do_reset();
    rdy_i = 3'b010; v_i = '0; data_i = '0;
    exp_q.push_back({2'd1, d});
    run(50, ncyc);
    chk_status("tmo", ncyc, 11, 16'd1, 4'd0);
    chk("halt_done", 64'(h_done), 64'd1);
    chk("halt_error", 64'(h_error), 64'd1);
    chk("halt_count", 64'(h_err_count), 64'd1);
    chk("halt_eaddr", 64'(h_err_addr), 64'd0);

    // Illegal opcode and out-of-range channel: no handshake signals
    fill_rom(k_finish);
    rom[0] = ent(k_ill, 2'd0, '0, '0);
    rom[1] = ent(k_send, 2'd3, 64'h7777, '0);
    do_reset();
    rdy_i = '1; v_i = '1; data_i = '0;
    run(50, ncyc);
    chk_status("ill", ncyc, 4, 16'd2, 4'd0);
    chk("ill_no_pulse", 64'(any_pulse), 64'd0);

    // Reset in the middle of a WAIT, then restart from address 0
    fill_rom(k_finish);
    rom[0] = ent(k_ill, 2'd0, '0, '0);
    rom[1] = ent(k_wait, 2'd0, 64'd20, '0);
    do_reset();
    rdy_i = '1; v_i = '0; data_i = '0;
    en_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_addr", 64'(rom_addr), 64'd1);
    chk("mid_error", 64'(error), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_addr", 64'(rom_addr), 64'd0);
    chk("arst_v_o", 64'(v_o), 64'd0);
    chk("arst_rdy_o", 64'(rdy_o), 64'd0);
    chk("arst_data_o", data_o, 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_error", 64'(error), 64'd0);
    chk("arst_count", 64'(err_count), 64'd0);
    chk("arst_eaddr", 64'(err_addr), 64'd0);
    rst = 1'b0;
    run(100, ncyc);
    chk_status("restart", ncyc, 25, 16'd1, 4'd0);

    // No FINISH anywhere: runaway off the last address
    fill_rom(k_nop);
    do_reset();
    run(50, ncyc);
    chk_status("runaway", ncyc, 17, 16'd1, 4'd15);
    chk("runaway_addr", 64'(rom_addr), 64'd15);

    // Back-to-back random sends with an always-ready DUT
    fill_rom(k_finish);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rch = cw'($urandom_range(nc - 1, 0));
      a   = {$urandom, $urandom};
      rom[i] = ent(k_send, rch, a, '0);
      exp_q.push_back({rch, a});
    end
    rdy_i = '1; v_i = '0; data_i = '0;
    run(50, ncyc);
    chk_status("burst", ncyc, 10, 16'd0, 4'd0);
    chk("burst_hs_count", 64'(hs_q.size()), 64'd8);
    if (hs_q.size() == 8) chk("burst_span", 64'(hs_q[7] - hs_q[0]), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
